vote_tally: RTL and testbench
=============================

VOTE_TALLY -- requirements
Module: vote_tally

Interface
REQ-001 Parameter CNT_W, default 8, per-candidate counter width in bits.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 vv1, vv2, vv3  input  1 each  validated-vote strobes for candidates 1..3, synchronous to clk.
REQ-005 close_poll  input  1  authority request to end polling; level, acted on at its rising edge.
REQ-006 count1, count2, count3  output  CNT_W each  per-candidate vote totals.
REQ-007 total  output  CNT_W+2  sum of count1..count3.
REQ-008 poll_open  output  1  high while votes are accepted.
REQ-009 result_valid  output  1  high when winner/tie are final.
REQ-010 winner  output  2  0 = none, 1..3 = candidate index.
REQ-011 tie  output  1  top count shared by two or more candidates.
REQ-012 sat_err  output  1  sticky; a vote was dropped because a counter was saturated.
REQ-013 multi_err  output  1  sticky; simultaneous vote strobes were rejected.

Function
REQ-014 The FSM SHALL have states OPEN, CLOSED and DONE; reset enters OPEN.
REQ-015 Each vv input SHALL be rising-edge detected against a registered copy; a level held high for N cycles counts as one vote.
REQ-016 In OPEN, a single detected edge on vvK at posedge n SHALL increment countK, with the new value visible after posedge n (one-cycle latency from the sampled edge).
REQ-017 Edges detected on two or more vv inputs in the same cycle SHALL increment no counter and SHALL set multi_err.
REQ-018 A counter at 2^CNT_W-1 SHALL hold its value on a further vote, and sat_err SHALL be set.
REQ-019 total SHALL be the registered zero-extended sum of the three counts, updated in the same cycle as the counts.
REQ-020 A rising edge of close_poll in OPEN SHALL move to CLOSED; poll_open SHALL fall in the same cycle.
REQ-021 A vote edge coincident with the close_poll edge SHALL be counted; edges in CLOSED or DONE SHALL be ignored without flagging errors.
REQ-022 CLOSED SHALL last exactly one cycle, registering winner/tie, then move to DONE with result_valid = 1.
REQ-023 winner SHALL be the index of the strictly largest count; with all counts zero winner = 0 and tie = 0; with a shared maximum winner = 0 and tie = 1.
REQ-024 DONE SHALL be held until reset; close_poll in CLOSED or DONE SHALL have no effect.

Reset
REQ-025 Reset SHALL force OPEN, all counts and total to 0, poll_open = 1, result_valid = 0, winner = 0, tie = 0, sat_err = 0, multi_err = 0, and edge-detect registers to 0.
REQ-026 Reset SHALL take priority over every other input in any state, including mid-vote and in CLOSED.
REQ-027 A vv input held high through the deassertion of reset SHALL count once, at the first cycle out of reset.

Configuration
REQ-028 Macro VOTE_TALLY_WINNER_EN SHALL select the winner logic.
REQ-029 With VOTE_TALLY_WINNER_EN defined, winner and tie SHALL behave per REQ-022 and REQ-023.
REQ-030 Without VOTE_TALLY_WINNER_EN, winner and tie SHALL be tied to 0; result_valid and all other behaviour SHALL be unchanged.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the winner codes (NONE = 0, C1..C3), and the default CNT_W.
REQ-032 The rising-edge detector SHALL be a sub-module, edge_det, instantiated once per vv input and once for close_poll.

Verification
REQ-033 Reset, then a 1-cycle pulse on each of vv1, vv2, vv1 -> count1 = 2, count2 = 1, count3 = 0, total = 3, each value visible one cycle after its edge.
REQ-034 vv2 held high for 10 cycles -> count2 = 1.
REQ-035 vv1 and vv3 pulsed in the same cycle -> no count changes and multi_err = 1; multi_err stays at 1 until reset.
REQ-036 CNT_W = 2, five vv3 pulses -> count3 = 3 and sat_err = 1.
REQ-037 Counts 4/2/1, then close_poll -> poll_open = 0 next cycle; one cycle later result_valid = 1, winner = 1, tie = 0; a later vv2 leaves count2 = 2.
REQ-038 Counts 3/3/0, then close_poll -> winner = 0, tie = 1 (macro defined); winner = 0, tie = 0 (macro undefined); reset asserted in DONE -> all outputs return to their REQ-025 values.

Source files
------------

// File: rtl/vote_tally_pkg.sv
// Shared definitions for the three-candidate vote tally: FSM encoding,
// winner codes, default counter width and a small strobe-count helper.
package vote_tally_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_CLOSED = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_C1   = 2'd1,
    WIN_C2   = 2'd2,
    WIN_C3   = 2'd3
  } winner_e;

  // Number of strobes set among three; used to tell single from multi votes.
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    popcount3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector: compares the input against a registered copy that
// is cleared by reset, so a level held through reset release reads as an edge.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/vote_tally.sv
// Three-candidate vote tally with saturating counters, poll close and result
// registration. Define VOTE_TALLY_WINNER_EN to enable the winner/tie logic.
module vote_tally
  import vote_tally_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vv1,
  input  logic             vv2,
  input  logic             vv3,
  input  logic             close_poll,
  output logic [CNT_W-1:0] count1,
  output logic [CNT_W-1:0] count2,
  output logic [CNT_W-1:0] count3,
  output logic [CNT_W+1:0] total,
  output logic             poll_open,
  output logic             result_valid,
  output logic [1:0]       winner,
  output logic             tie,
  output logic             sat_err,
  output logic             multi_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0] vv_rise;
  logic       close_rise;

  edge_det u_edge_vv1   (.clk(clk), .reset(reset), .d(vv1),        .rise(vv_rise[0]));
  edge_det u_edge_vv2   (.clk(clk), .reset(reset), .d(vv2),        .rise(vv_rise[1]));
  edge_det u_edge_vv3   (.clk(clk), .reset(reset), .d(vv3),        .rise(vv_rise[2]));
  edge_det u_edge_close (.clk(clk), .reset(reset), .d(close_poll), .rise(close_rise));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q [3];
  logic [CNT_W-1:0] count_d [3];
  logic [CNT_W+1:0] total_q, total_d;
  logic             poll_open_q, poll_open_d;
  logic             result_valid_q, result_valid_d;
  winner_e          winner_q, winner_d;
  logic             tie_q, tie_d;
  logic             sat_err_q, sat_err_d;
  logic             multi_err_q, multi_err_d;
  winner_e          win_s;
  logic             tie_s;

`ifdef VOTE_TALLY_WINNER_EN
  // A strict maximum names a winner; otherwise a non-zero shared top is a tie.
  always_comb begin
    win_s = WIN_NONE;
    tie_s = 1'b0;
    if ((count_q[0] > count_q[1]) && (count_q[0] > count_q[2])) begin
      win_s = WIN_C1;
    end else if ((count_q[1] > count_q[0]) && (count_q[1] > count_q[2])) begin
      win_s = WIN_C2;
    end else if ((count_q[2] > count_q[0]) && (count_q[2] > count_q[1])) begin
      win_s = WIN_C3;
    end else if ((count_q[0] == '0) && (count_q[1] == '0) && (count_q[2] == '0)) begin
      tie_s = 1'b0;
    end else begin
      tie_s = 1'b1;
    end
  end
`else
  assign win_s = WIN_NONE;
  assign tie_s = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    sat_err_d      = sat_err_q;
    multi_err_d    = multi_err_q;
    winner_d       = winner_q;
    tie_d          = tie_q;
    result_valid_d = result_valid_q;

    case (state_q)
      ST_OPEN: begin
        if (popcount3(vv_rise) > 2'd1) begin
          multi_err_d = 1'b1;
        end else begin
          for (int k = 0; k < 3; k++) begin
            if (!vv_rise[k]) begin
              count_d[k] = count_q[k];
            end else if (count_q[k] == CNT_MAX) begin
              sat_err_d = 1'b1;
            end else begin
              count_d[k] = count_q[k] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        if (close_rise) begin
          state_d = ST_CLOSED;
        end else begin
          state_d = ST_OPEN;
        end
      end
      ST_CLOSED: begin
        winner_d       = win_s;
        tie_d          = tie_s;
        result_valid_d = 1'b1;
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_OPEN;
      end
    endcase

    total_d = {2'b00, count_d[0]} + {2'b00, count_d[1]} + {2'b00, count_d[2]};
    poll_open_d = (state_d == ST_OPEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_OPEN;
      count_q[0]     <= '0;
      count_q[1]     <= '0;
      count_q[2]     <= '0;
      total_q        <= '0;
      poll_open_q    <= 1'b1;
      result_valid_q <= 1'b0;
      winner_q       <= WIN_NONE;
      tie_q          <= 1'b0;
      sat_err_q      <= 1'b0;
      multi_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q[0]     <= count_d[0];
      count_q[1]     <= count_d[1];
      count_q[2]     <= count_d[2];
      total_q        <= total_d;
      poll_open_q    <= poll_open_d;
      result_valid_q <= result_valid_d;
      winner_q       <= winner_d;
      tie_q          <= tie_d;
      sat_err_q      <= sat_err_d;
      multi_err_q    <= multi_err_d;
    end
  end

  assign count1       = count_q[0];
  assign count2       = count_q[1];
  assign count3       = count_q[2];
  assign total        = total_q;
  assign poll_open    = poll_open_q;
  assign result_valid = result_valid_q;
  assign winner       = winner_q;
  assign tie          = tie_q;
  assign sat_err      = sat_err_q;
  assign multi_err    = multi_err_q;

endmodule

// File: tb/tb_vote_tally.sv
// Scoreboard bench for vote_tally: a behavioural model predicts every output
// per cycle; expectations are queued on drive and popped after the clock edge.
module tb_vote_tally;

  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vv1 = 1'b0, vv2 = 1'b0, vv3 = 1'b0, close_poll = 1'b0;
  logic [CW-1:0] count1, count2, count3;
  logic [CW+1:0] total;
  logic          poll_open, result_valid, tie, sat_err, multi_err;
  logic [1:0]    winner;

  vote_tally #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .vv1(vv1), .vv2(vv2), .vv3(vv3),
    .close_poll(close_poll), .count1(count1), .count2(count2), .count3(count3),
    .total(total), .poll_open(poll_open), .result_valid(result_valid),
    .winner(winner), .tie(tie), .sat_err(sat_err), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c1, c2, c3, tot, po, rv, win, tie, sat, multi;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int m_cnt[3];
  int m_prev[4];
  int m_st, m_win, m_tie, m_rv, m_sat, m_multi;

  task automatic check_eq(input string tag, input int got, input int exp_v);
    n_checks++;
    if (got == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
  endtask

  task automatic model_step(input int i1, input int i2, input int i3, input int cp, input int rst);
    exp_t e;
    int   in_v[4];
    int   ed[4];
    int   ne, mx, nmx, idx;
    in_v = '{i1, i2, i3, cp};
    if (rst != 0) begin
      m_cnt = '{0, 0, 0};
      m_prev = '{0, 0, 0, 0};
      m_st = 0; m_win = 0; m_tie = 0; m_rv = 0; m_sat = 0; m_multi = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        ed[k] = (in_v[k] != 0 && m_prev[k] == 0) ? 1 : 0;
        m_prev[k] = in_v[k];
      end
      ne = ed[0] + ed[1] + ed[2];
      if (m_st == 0) begin
        if (ne > 1) m_multi = 1;
        else if (ne == 1) begin
          for (int k = 0; k < 3; k++)
            if (ed[k] != 0) begin
              if (m_cnt[k] == CMAX) m_sat = 1;
              else m_cnt[k] = m_cnt[k] + 1;
            end
        end
        if (ed[3] != 0) m_st = 1;
      end else if (m_st == 1) begin
        mx = 0; nmx = 0; idx = 0;
        for (int k = 0; k < 3; k++) if (m_cnt[k] > mx) begin mx = m_cnt[k]; idx = k + 1; end
        for (int k = 0; k < 3; k++) if (m_cnt[k] == mx) nmx++;
`ifdef VOTE_TALLY_WINNER_EN
        if (mx == 0) begin m_win = 0; m_tie = 0; end
        else if (nmx > 1) begin m_win = 0; m_tie = 1; end
        else begin m_win = idx; m_tie = 0; end
`else
        m_win = 0; m_tie = 0;
`endif
        m_rv = 1;
        m_st = 2;
      end
    end
    e.c1 = m_cnt[0]; e.c2 = m_cnt[1]; e.c3 = m_cnt[2];
    e.tot = m_cnt[0] + m_cnt[1] + m_cnt[2];
    e.po = (m_st == 0) ? 1 : 0;
    e.rv = m_rv; e.win = m_win; e.tie = m_tie; e.sat = m_sat; e.multi = m_multi;
    sb_q.push_back(e);
  endtask

  task automatic step(input int i1, input int i2, input int i3, input int cp, input int rst);
    exp_t e;
    @(negedge clk);
    vv1 = (i1 != 0); vv2 = (i2 != 0); vv3 = (i3 != 0);
    close_poll = (cp != 0); reset = (rst != 0);
    model_step(i1, i2, i3, cp, rst);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_eq("count1", int'(count1), e.c1);
      check_eq("count2", int'(count2), e.c2);
      check_eq("count3", int'(count3), e.c3);
      check_eq("total", int'(total), e.tot);
      check_eq("poll_open", int'(poll_open), e.po);
      check_eq("result_valid", int'(result_valid), e.rv);
      check_eq("winner", int'(winner), e.win);
      check_eq("tie", int'(tie), e.tie);
      check_eq("sat_err", int'(sat_err), e.sat);
      check_eq("multi_err", int'(multi_err), e.multi);
    end
  endtask

  task automatic pulse(input int i1, input int i2, input int i3);
    step(i1, i2, i3, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
  endtask

  int exp_w, exp_t_v;

  initial begin
    do_reset();
    check_eq("rst_poll_open", int'(poll_open), 1);
    check_eq("rst_total", int'(total), 0);

    // Basic counting, one-cycle latency.
    step(1, 0, 0, 0, 0);
    check_eq("r033_c1_first", int'(count1), 1);
    step(0, 0, 0, 0, 0);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    check_eq("r033_c1", int'(count1), 2);
    check_eq("r033_c2", int'(count2), 1);
    check_eq("r033_c3", int'(count3), 0);
    check_eq("r033_total", int'(total), 3);

    // Held level counts once.
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("r034_c2", int'(count2), 1);

    // Simultaneous strobes rejected, sticky error.
    do_reset();
    pulse(1, 0, 1);
    check_eq("r035_multi", int'(multi_err), 1);
    check_eq("r035_c1", int'(count1), 0);
    pulse(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    check_eq("r035_multi_sticky", int'(multi_err), 1);

    // Saturation at the counter ceiling.
    do_reset();
    for (int i = 0; i < CMAX + 2; i++) pulse(0, 0, 1);
    check_eq("r036_c3", int'(count3), CMAX);
    check_eq("r036_sat", int'(sat_err), 1);

    // Clear winner 4/2/1; late votes ignored; close_poll after DONE ignored.
    do_reset();
    for (int i = 0; i < 4; i++) pulse(1, 0, 0);
    for (int i = 0; i < 2; i++) pulse(0, 1, 0);
    pulse(0, 0, 1);
    step(0, 0, 0, 1, 0);
    check_eq("r037_poll_open", int'(poll_open), 0);
    step(0, 0, 0, 1, 0);
`ifdef VOTE_TALLY_WINNER_EN
    exp_w = 1;
`else
    exp_w = 0;
`endif
    check_eq("r037_rv", int'(result_valid), 1);
    check_eq("r037_winner", int'(winner), exp_w);
    check_eq("r037_tie", int'(tie), 0);
    pulse(0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check_eq("r037_c2_late", int'(count2), 2);
    check_eq("r037_multi_late", int'(multi_err), 0);

    // Tie 3/3/0 and reset from DONE.
    do_reset();
    for (int i = 0; i < 3; i++) begin pulse(1, 0, 0); pulse(0, 1, 0); end
    pulse(0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
`ifdef VOTE_TALLY_WINNER_EN
    exp_t_v = 1;
`else
    exp_t_v = 0;
`endif
    check_eq("r038_winner", int'(winner), 0);
    check_eq("r038_tie", int'(tie), exp_t_v);
    step(0, 0, 0, 0, 1);
    check_eq("r038_rst_rv", int'(result_valid), 0);
    check_eq("r038_rst_po", int'(poll_open), 1);

    // Vote held through reset release counts once; reset wins mid-vote.
    step(1, 0, 0, 0, 1);
    check_eq("r026_c1", int'(count1), 0);
    step(1, 0, 0, 0, 0);
    check_eq("r027_c1", int'(count1), 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Vote coincident with close is counted; reset in CLOSED.
    step(0, 1, 0, 1, 0);
    check_eq("r021_c2", int'(count2), 1);
    step(0, 0, 0, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step(($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 3) == 0) ? 1 : 0,
           ($urandom_range(0, 3) == 0) ? 1 : 0, (r < 4) ? 1 : 0, (r == 99) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
